// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl: sequential driver/consumer closing the recurrence loop of a combinational LSTM cell
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_in_valid/o_in_ready/i_in_data   X sample stream (i_in_first zeroes c/h, i_in_last tags sequence end)
//   o_cell_x/o_cell_c/o_cell_h        registered inputs to the cell
//   i_cell_c_out/i_cell_h_out         cell results, captured CELL_LAT cycles after the inputs settle
//   o_out_valid/i_out_ready           result handshake carrying o_out_h, o_out_c, o_out_last, o_step_idx
//   o_busy                            controller not idle
//   o_clamp_hit                       sticky c saturation flag (only with LSTM_STATE_CLAMP_EN)
// Build option: define LSTM_STATE_CLAMP_EN to saturate captured c to [-C_CLAMP, +C_CLAMP].
module lstm_seq_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int FRACT_WIDTH = 8,
    parameter int CELL_LAT = 1,
    parameter int CNT_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] C_CLAMP = 16'h0800
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    input  logic                  i_in_first,
    input  logic                  i_in_last,
    output logic [DATA_WIDTH-1:0] o_cell_x,
    output logic [DATA_WIDTH-1:0] o_cell_c,
    output logic [DATA_WIDTH-1:0] o_cell_h,
    input  logic [DATA_WIDTH-1:0] i_cell_c_out,
    input  logic [DATA_WIDTH-1:0] i_cell_h_out,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_WIDTH-1:0] o_out_h,
    output logic [DATA_WIDTH-1:0] o_out_c,
    output logic                  o_out_last,
    output logic [CNT_WIDTH-1:0]  o_step_idx,
    output logic                  o_busy
`ifdef LSTM_STATE_CLAMP_EN
    ,
    output logic                  o_clamp_hit
`endif
);
    if (CELL_LAT < 0 || CELL_LAT > 15) begin : g_bad_lat
        $error("CELL_LAT must be 0..15");
    end
    if (FRACT_WIDTH >= DATA_WIDTH) begin : g_bad_fract
        $error("FRACT_WIDTH must be below DATA_WIDTH");
    end
    typedef enum logic [1:0] {IDLE, EVAL, OUT} state_t;
    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_x;
    logic [DATA_WIDTH-1:0] r_c;
    logic [DATA_WIDTH-1:0] r_h;
    logic                  r_last;
    logic [CNT_WIDTH-1:0]  r_seq;
    logic                  w_accept;
    logic                  w_capture;
    logic [DATA_WIDTH-1:0] w_c_cap;
    assign w_accept = (r_state == IDLE) && i_in_valid;
    assign w_capture = (r_state == EVAL) && (r_cnt == 4'd0);
    assign o_in_ready = (r_state == IDLE);
    assign o_out_valid = (r_state == OUT);
    assign o_busy = (r_state != IDLE);
    assign o_cell_x = r_x;
    assign o_cell_c = r_c;
    assign o_cell_h = r_h;
`ifdef LSTM_STATE_CLAMP_EN
    logic [DATA_WIDTH-1:0] w_neg;
    logic                  w_hi;
    logic                  w_lo;
    logic                  r_clamp_hit;
    assign w_neg = -C_CLAMP;
    assign w_hi = $signed(i_cell_c_out) > $signed(C_CLAMP);
    assign w_lo = $signed(i_cell_c_out) < $signed(w_neg);
    assign w_c_cap = w_hi ? C_CLAMP : (w_lo ? w_neg : i_cell_c_out);
    assign o_clamp_hit = r_clamp_hit;
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_clamp_hit <= 1'b0;
        else if (w_accept && i_in_first)
            r_clamp_hit <= 1'b0;
        else if (w_capture && (w_hi || w_lo))
            r_clamp_hit <= 1'b1;
    end
`else
    assign w_c_cap = i_cell_c_out;
`endif
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_in_valid ? EVAL : IDLE;
            EVAL:    w_next = (r_cnt == 4'd0) ? OUT : EVAL;
            OUT:     w_next = i_out_ready ? IDLE : OUT;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_x        <= '0;
            r_c        <= '0;
            r_h        <= '0;
            r_last     <= 1'b0;
            r_seq      <= '0;
            o_out_h    <= '0;
            o_out_c    <= '0;
            o_out_last <= 1'b0;
            o_step_idx <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_x    <= i_in_data;
                r_last <= i_in_last;
                r_cnt  <= 4'(CELL_LAT);
                r_seq  <= i_in_first ? '0 : r_seq + 1'b1;
                if (i_in_first) begin
                    r_c <= '0;
                    r_h <= '0;
                end
            end
            if (r_state == EVAL && r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
            if (w_capture) begin
                r_c        <= w_c_cap;
                r_h        <= i_cell_h_out;
                o_out_c    <= w_c_cap;
                o_out_h    <= i_cell_h_out;
                o_out_last <= r_last;
                o_step_idx <= r_seq;
            end
        end
    end
endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// tb_lstm_seq_ctrl: table-driven scoreboard bench for lstm_seq_ctrl with a stubbed cell
module tb_lstm_seq_ctrl;
    localparam int DW = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [DW-1:0] in_data = '0;
    logic in_first = 1'b0;
    logic in_last = 1'b0;
    logic [DW-1:0] cell_x, cell_c, cell_h;
    logic [DW-1:0] stub_c = '0;
    logic [DW-1:0] stub_h = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic [DW-1:0] out_h, out_c;
    logic out_last;
    logic [7:0] step_idx;
    logic busy;
`ifdef LSTM_STATE_CLAMP_EN
    logic clamp_hit;
    logic m_hit = 1'b0;
`endif
    lstm_seq_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_data(in_data), .i_in_first(in_first), .i_in_last(in_last),
        .o_cell_x(cell_x), .o_cell_c(cell_c), .o_cell_h(cell_h),
        .i_cell_c_out(stub_c), .i_cell_h_out(stub_h),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_h(out_h), .o_out_c(out_c),
        .o_out_last(out_last), .o_step_idx(step_idx), .o_busy(busy)
`ifdef LSTM_STATE_CLAMP_EN
        , .o_clamp_hit(clamp_hit)
`endif
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [DW-1:0] x;
        logic          first;
        logic          last;
        logic [DW-1:0] sc;
        logic [DW-1:0] sh;
        logic [7:0]    step;
        int            stall;
    } vec_t;
    typedef struct {
        logic [DW-1:0] h;
        logic [DW-1:0] c;
        logic          last;
        logic [7:0]    step;
    } exp_t;
    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    logic [DW-1:0] m_c = '0;
    logic [DW-1:0] m_h = '0;
    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask
    function automatic logic [DW-1:0] clampf(input logic [DW-1:0] v);
`ifdef LSTM_STATE_CLAMP_EN
        if ($signed(v) > 16'sh0800) return 16'h0800;
        if ($signed(v) < -16'sh0800) return 16'hF800;
`endif
        return v;
    endfunction
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_h", 32'(out_h), 32'(e.h));
                chk("out_c", 32'(out_c), 32'(e.c));
                chk("out_last", 32'(out_last), 32'(e.last));
                chk("step_idx", 32'(step_idx), 32'(e.step));
            end
        end
    end
    task automatic run_step(input vec_t v);
        int n;
        logic [DW-1:0] ec;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_data = v.x;
        in_first = v.first;
        in_last = v.last;
        in_valid = 1'b1;
        stub_c = v.sc;
        stub_h = v.sh;
        ec = clampf(v.sc);
        if (v.first) begin
            m_c = '0;
            m_h = '0;
        end
        sb.push_back('{v.sh, ec, v.last, v.step});
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data = 16'hDEAD;
        in_first = 1'b0;
        in_last = 1'b0;
        chk("cell_x", 32'(cell_x), 32'(v.x));
        chk("cell_c", 32'(cell_c), 32'(m_c));
        chk("cell_h", 32'(cell_h), 32'(m_h));
        chk("busy_eval", 32'(busy), 32'd1);
        chk("in_ready_eval", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("out_valid_early", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("out_valid_lat", 32'(out_valid), 32'd1);
        m_c = ec;
        m_h = v.sh;
`ifdef LSTM_STATE_CLAMP_EN
        if (v.first) m_hit = 1'b0;
        if (ec != v.sc) m_hit = 1'b1;
        chk("clamp_hit", 32'(clamp_hit), 32'(m_hit));
`endif
        for (int i = 0; i < v.stall; i++) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_h", 32'(out_h), 32'(v.sh));
            chk("hold_c", 32'(out_c), 32'(ec));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_drop", 32'(out_valid), 32'd0);
    endtask
    vec_t vt[9];
    initial begin
        vt[0] = '{16'h0100, 1'b1, 1'b1, 16'h0180, 16'h0040, 8'd0, 0};
        vt[1] = '{16'h0011, 1'b1, 1'b0, 16'h0001, 16'h0001, 8'd0, 0};
        vt[2] = '{16'h0022, 1'b0, 1'b0, 16'h0002, 16'h0002, 8'd1, 5};
        vt[3] = '{16'h0033, 1'b0, 1'b1, 16'h0003, 16'h0003, 8'd2, 1};
        vt[4] = '{16'h0044, 1'b0, 1'b0, 16'h8000, 16'h7FFF, 8'd3, 0};
        vt[5] = '{16'h8000, 1'b1, 1'b1, 16'hFFFF, 16'h0040, 8'd0, 2};
        vt[6] = '{16'h7FFF, 1'b1, 1'b0, 16'h1234, 16'hABCD, 8'd0, 0};
        vt[7] = '{16'hFFFF, 1'b0, 1'b1, 16'h0A00, 16'h0001, 8'd1, 0};
        vt[8] = '{16'h0077, 1'b0, 1'b0, 16'hF000, 16'h0002, 8'd2, 3};
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cell_c", 32'(cell_c), 32'd0);
        chk("rst_out_h", 32'(out_h), 32'd0);
        for (int i = 0; i < 9; i++) run_step(vt[i]);
        in_data = 16'h0055;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_cell_c", 32'(cell_c), 32'd0);
        chk("mid_rst_cell_h", 32'(cell_h), 32'd0);
        chk("mid_rst_cell_x", 32'(cell_x), 32'd0);
        chk("mid_rst_step", 32'(step_idx), 32'd0);
        m_c = '0;
        m_h = '0;
`ifdef LSTM_STATE_CLAMP_EN
        m_hit = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("no_stale_result", 32'(out_valid), 32'd0);
        run_step('{16'h0066, 1'b0, 1'b1, 16'h0005, 16'h0006, 8'd1, 0});
        @(posedge clk); #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
